decoder_2_4_bh: RTL and testbench
=================================

// Module: decoder_2_4_bh
//
// PURPOSE
//   2-to-4 line decoder with active-high enable. Drives exactly one of four
//   one-hot outputs selected by a 2-bit code while enabled, all-zero otherwise.
//   Provides an immediate combinational output and a registered copy for
//   timing-clean consumers. Leaf block used by address/select decode logic.
//
// PARAMETERS
//   ACTIVE_LOW_OUT  0  1: invert y and y_q polarity (one-cold); 0: one-hot
//   REG_RESET_VAL   4'b0000  reset value loaded into y_q (before polarity inversion)
//
// PORTS
//   clk    in   1  system clock, rising-edge
//   rst_n  in   1  asynchronous active-low reset
//   y      out  4  combinational decoded output
//   i      in   2  select code
//   e      in   1  enable, active-high
//   y_q    out  4  y registered on clk
//   vld_q  out  1  registered e (y_q holds a valid decode)
//   Declaration order is y, i, e, clk, rst_n, y_q, vld_q, so that existing
//   positional instantiations (y, i, e) bind correctly.
//
// BEHAVIOUR
//   - Combinational path, zero latency, no clock dependence:
//       e=1: y = 4'b0001 << i  (i=00->0001, 01->0010, 10->0100, 11->1000)
//       e=0: y = 4'b0000 regardless of i
//   - ACTIVE_LOW_OUT=1: y = ~(above); e=0 then gives 4'b1111.
//   - X/Z on i or e: y driven 4'bxxxx in simulation (no silent default);
//     synthesis treats the default branch as don't-care.
//   - Registered path: on each rising clk, y_q <= y and vld_q <= e.
//     Latency 1 cycle. No stall or hold input; y_q updates every cycle.
//   - Reset: rst_n low asynchronously forces y_q = REG_RESET_VAL (polarity
//     applied) and vld_q = 0. Release is synchronous to the next clk edge.
//     The combinational y is unaffected by reset.
//   - Reset asserted mid-operation: y_q/vld_q clear immediately, without
//     waiting for clk. The first edge after release captures the current y.
//   - Invariant: with e=1, y (and y_q when vld_q=1) is exactly one-hot
//     (one-cold if inverted). With e=0, the output is all-inactive.
//   - Simultaneous i and e change: y settles to the decode of the new pair;
//     no glitch requirement.
//
// STRUCTURE
//   - Shared package: localparam DEC_W=4, SEL_W=2, and the one-hot-check
//     function is_onehot4() for reuse by other decoders and assertions.
//   - Single always_comb case on i, gated by e. Single always_ff with
//     asynchronous negedge rst_n for y_q and vld_q.
//   - Embedded assertions (sim only): one-hot when e=1; zero when e=0;
//     y_q == $past(y) when out of reset.
//   - No sub-module; the block is flat.
//
// TESTING
//   1. e=1, i=00,01,10,11 held 10 ns each -> y=0001,0010,0100,1000 immediately.
//   2. e=0, i=00 then i=11 -> y=0000 both times.
//   3. Clocked sweep with e=1, i=10 -> y_q=0100 and vld_q=1 one edge later.
//   4. rst_n low mid-sweep between edges -> y_q=0000 and vld_q=0 at once;
//      y still follows i.
//   5. ACTIVE_LOW_OUT=1: e=1, i=01 -> y=1101; e=0 -> y=1111.
//   6. Random i/e for 1000 cycles -> one-hot and y_q==$past(y) assertions hold.

Source files
------------

// File: rtl/decoder_2_4_bh_pkg.sv
// Shared widths and one-hot helper for the 2-to-4 decoder family.
package decoder_2_4_bh_pkg;

    localparam int DEC_W = 4;
    localparam int SEL_W = 2;

    function automatic logic is_onehot4(input logic [DEC_W-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/decoder_2_4_bh.sv
// 2-to-4 line decoder, active-high enable, with combinational
// output and a registered copy plus valid flag.
module decoder_2_4_bh
    import decoder_2_4_bh_pkg::*;
#(
    parameter bit               ACTIVE_LOW_OUT = 1'b0,
    parameter logic [DEC_W-1:0] REG_RESET_VAL  = '0
) (
    output logic [DEC_W-1:0] y,
    input  logic [SEL_W-1:0] i,
    input  logic             e,
    input  logic             clk,
    input  logic             rst_n,
    output logic [DEC_W-1:0] y_q,
    output logic             vld_q
);

    localparam logic [DEC_W-1:0] RST_Q =
        ACTIVE_LOW_OUT ? ~REG_RESET_VAL : REG_RESET_VAL;

    logic [DEC_W-1:0] dec;
    logic [DEC_W-1:0] y_d;
    logic             vld_d;

    // Unknown select/enable propagates as X rather than a silent default
    always_comb begin
        dec = '0;
        case ({e, i})
            3'b100:  dec = 4'b0001;
            3'b101:  dec = 4'b0010;
            3'b110:  dec = 4'b0100;
            3'b111:  dec = 4'b1000;
            3'b000,
            3'b001,
            3'b010,
            3'b011:  dec = 4'b0000;
            default: dec = 'x;
        endcase
    end

    assign y     = ACTIVE_LOW_OUT ? ~dec : dec;
    assign y_d   = y;
    assign vld_d = e;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q   <= RST_Q;
            vld_q <= 1'b0;
        end else begin
            y_q   <= y_d;
            vld_q <= vld_d;
        end
    end

    a_onehot: assert property (@(posedge clk)
        (e === 1'b1) && !$isunknown(i) |->
            is_onehot4(ACTIVE_LOW_OUT ? ~y : y));

    a_idle: assert property (@(posedge clk)
        (e === 1'b0) |-> (y == (ACTIVE_LOW_OUT ? 4'b1111 : 4'b0000)));

    a_reg: assert property (@(posedge clk) disable iff (!rst_n)
        $past(rst_n) |-> (y_q == $past(y)));

endmodule

// File: tb/tb_decoder_2_4_bh.sv
// Scoreboard bench for decoder_2_4_bh: one-hot and inverted instances.
module tb_decoder_2_4_bh;

    typedef struct packed {
        logic [3:0] y;
        logic [3:0] yq;
        logic       vld;
        logic [3:0] yn;
        logic [3:0] yqn;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] i = 2'b00;
    logic       e = 1'b0;
    logic [3:0] y, y_q, yn, yn_q;
    logic       vld_q, vldn_q;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    decoder_2_4_bh dut (
        .y(y), .i(i), .e(e), .clk(clk), .rst_n(rst_n),
        .y_q(y_q), .vld_q(vld_q)
    );

    decoder_2_4_bh #(.ACTIVE_LOW_OUT(1'b1)) dut_n (
        .y(yn), .i(i), .e(e), .clk(clk), .rst_n(rst_n),
        .y_q(yn_q), .vld_q(vldn_q)
    );

    function automatic void chk(string nm, logic [3:0] act, logic [3:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, req, $time);
        end
    endfunction

    // Monitor: compare between clock edges against the oldest expectation
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk("y", y, x.y);
                chk("y_q", y_q, x.yq);
                chk("vld_q", {3'b0, vld_q}, {3'b0, x.vld});
                chk("yn", yn, x.yn);
                chk("yn_q", yn_q, x.yqn);
                chk("vldn_q", {3'b0, vldn_q}, {3'b0, x.vld});
            end
        end
    end

    task automatic step(input logic r, input logic [1:0] ii, input logic ee,
                        input logic [3:0] ey, input logic [3:0] eyq,
                        input logic ev, input logic [3:0] eyn,
                        input logic [3:0] eyqn);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n = r;
        i     = ii;
        e     = ee;
        x = '{y: ey, yq: eyq, vld: ev, yn: eyn, yqn: eyqn};
        sb.push_back(x);
    endtask

    initial begin
        logic [3:0] py, cy;
        logic [1:0] ri;
        logic       re;
        // reset state and release
        step(0, 2'b00, 0, 4'b0000, 4'b0000, 0, 4'b1111, 4'b1111);
        step(0, 2'b00, 1, 4'b0001, 4'b0000, 0, 4'b1110, 4'b1111);
        step(1, 2'b00, 1, 4'b0001, 4'b0000, 0, 4'b1110, 4'b1111);
        // enabled decode sweep
        step(1, 2'b01, 1, 4'b0010, 4'b0001, 1, 4'b1101, 4'b1110);
        step(1, 2'b10, 1, 4'b0100, 4'b0010, 1, 4'b1011, 4'b1101);
        step(1, 2'b11, 1, 4'b1000, 4'b0100, 1, 4'b0111, 4'b1011);
        // disabled
        step(1, 2'b00, 0, 4'b0000, 4'b1000, 1, 4'b1111, 4'b0111);
        step(1, 2'b11, 0, 4'b0000, 4'b0000, 0, 4'b1111, 4'b1111);
        // registered path latency
        step(1, 2'b10, 1, 4'b0100, 4'b0000, 0, 4'b1011, 4'b1111);
        step(1, 2'b10, 1, 4'b0100, 4'b0100, 1, 4'b1011, 4'b1011);
        step(1, 2'b01, 1, 4'b0010, 4'b0100, 1, 4'b1101, 4'b1011);
        // async reset between edges, y keeps decoding
        step(0, 2'b11, 1, 4'b1000, 4'b0000, 0, 4'b0111, 4'b1111);
        step(0, 2'b00, 1, 4'b0001, 4'b0000, 0, 4'b1110, 4'b1111);
        step(1, 2'b11, 1, 4'b1000, 4'b0000, 0, 4'b0111, 4'b1111);
        step(1, 2'b01, 0, 4'b0000, 4'b1000, 1, 4'b1111, 4'b0111);
        step(1, 2'b01, 1, 4'b0010, 4'b0000, 0, 4'b1101, 4'b1111);
        step(1, 2'b00, 1, 4'b0001, 4'b0010, 1, 4'b1110, 4'b1101);
        // random phase with a reference model
        py = 4'b0001;
        re = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            ri = 2'($urandom_range(0, 3));
            re = 1'($urandom_range(0, 1));
            cy = re ? (4'b0001 << ri) : 4'b0000;
            step(1, ri, re, cy, py, (py != 4'b0000), ~cy, ~py);
            py = cy;
        end
        for (int k = 0; k < 10 && sb.size() > 0; k++)
            @(negedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d pending, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
